xnor_popcount_acc: RTL and testbench

Parametrised binarised-neuron array: CHANNELS neurons share one streamed input vector of WORDS × WORD_W bits. Each neuron XNORs every input word against its own stored weight word, accumulates the popcount across all WORDS beats, and compares the total against a per-channel programmable threshold. It succeeds the single-word, single-neuron xnor-popcount stage, adding multi-beat fan-in, multiple channels, runtime thresholds and valid/ready handshakes. It sits between the binarised activation stream and the next layer's input buffer.

---
 rtl/xnor_popcount_acc.sv | 158 +++++++++++++++
 tb/tb_xnor_popcount_acc.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/xnor_popcount_acc.sv
// Binarised-neuron array. Channels neurons share one streamed input vector of
// Words beats of WordW bits. Each neuron XNORs every beat against its own
// stored weight word, accumulates the popcount over the whole vector and
// compares the total against a per-channel programmable threshold.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clear_i             synchronous abort of the partial vector / pending result
//   weight_wr_i         write weight_i into weight[weight_ch_i][weight_addr_i]
//   weight_ch_i         channel select for weight and threshold writes
//   weight_addr_i       word index for weight writes
//   weight_i            weight data
//   thresh_wr_i         write thresh_i into threshold[weight_ch_i]
//   thresh_i            threshold data
//   pixels_valid_i/pixels_ready_o/pixels_i   input beat handshake, word 0 first
//   result_valid_o/result_ready_i            result handshake
//   result_o            bit c = pop[c] >= threshold[c]
//   result_pop_o        raw popcount per channel, channel 0 in LSBs
module xnor_popcount_acc #(
  parameter int unsigned WordW    = 32,
  parameter int unsigned Words    = 4,
  parameter int unsigned Channels = 4,
  localparam int unsigned AccW    = $clog2(WordW * Words + 1),
  localparam int unsigned ChW     = (Channels > 1) ? $clog2(Channels) : 1,
  localparam int unsigned AddrW   = (Words > 1) ? $clog2(Words) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     weight_wr_i,
  input  logic [ChW-1:0]           weight_ch_i,
  input  logic [AddrW-1:0]         weight_addr_i,
  input  logic [WordW-1:0]         weight_i,
  input  logic                     thresh_wr_i,
  input  logic [AccW-1:0]          thresh_i,
  input  logic                     pixels_valid_i,
  output logic                     pixels_ready_o,
  input  logic [WordW-1:0]         pixels_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [Channels-1:0]      result_o,
  output logic [Channels*AccW-1:0] result_pop_o
);

  typedef enum logic [0:0] {StAccum, StDone} state_e;

  localparam logic [AccW-1:0]  ThreshRst = AccW'(WordW * Words / 2);
  localparam logic [AddrW-1:0] LastBeat  = AddrW'(Words - 1);

  state_e                               state_q, state_d;
  logic                                 live_q;
  logic [AddrW-1:0]                     cnt_q, cnt_d;
  logic [Channels-1:0][AccW-1:0]        acc_q, acc_d;
  logic [Channels-1:0][AccW-1:0]        sum;
  logic [Channels-1:0][Words-1:0][WordW-1:0] weight_q, weight_d;
  logic [Channels-1:0][AccW-1:0]        thresh_q, thresh_d;
  logic [Channels-1:0][AccW-1:0]        pop_q, pop_d;
  logic [Channels-1:0]                  res_q, res_d;
  logic                                 beat;

  function automatic logic [AccW-1:0] popcount(input logic [WordW-1:0] w);
    logic [AccW-1:0] n;
    n = '0;
    for (int i = 0; i < int'(WordW); i++) begin
      n = n + AccW'(w[i]);
    end
    return n;
  endfunction

  // live_q keeps pixels_ready low while reset is held even though the
  // state register already sits in StAccum.
  assign pixels_ready_o = live_q && (state_q == StAccum);
  assign result_valid_o = (state_q == StDone);
  assign result_o       = res_q;
  assign result_pop_o   = pop_q;
  assign beat           = pixels_valid_i && pixels_ready_o;

  always_comb begin
    sum = '0;
    for (int c = 0; c < int'(Channels); c++) begin
      sum[c] = acc_q[c] + popcount(pixels_i ~^ weight_q[c][cnt_q]);
    end
  end

  // Storage writes; a beat in the same cycle still sees the old contents.
  always_comb begin
    weight_d = weight_q;
    thresh_d = thresh_q;
    if (weight_wr_i && (32'(weight_ch_i) < Channels) && (32'(weight_addr_i) < Words)) begin
      weight_d[weight_ch_i][weight_addr_i] = weight_i;
    end
    if (thresh_wr_i && (32'(weight_ch_i) < Channels)) begin
      thresh_d[weight_ch_i] = thresh_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pop_d   = pop_q;
    res_d   = res_q;
    if (clear_i) begin
      // Clear wins over a simultaneous beat or result_ready.
      state_d = StAccum;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        StAccum: begin
          if (beat) begin
            if (cnt_q == LastBeat) begin
              pop_d   = sum;
              for (int c = 0; c < int'(Channels); c++) begin
                res_d[c] = (sum[c] >= thresh_q[c]);
              end
              acc_d   = '0;
              cnt_d   = '0;
              state_d = StDone;
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          if (result_ready_i) begin
            state_d = StAccum;
          end
        end
        default: state_d = StAccum;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StAccum;
      live_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      weight_q <= '0;
      thresh_q <= {Channels{ThreshRst}};
      pop_q    <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      live_q   <= 1'b1;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      weight_q <= weight_d;
      thresh_q <= thresh_d;
      pop_q    <= pop_d;
      res_q    <= res_d;
    end
  end

endmodule

// File: tb/tb_xnor_popcount_acc.sv
module tb_xnor_popcount_acc;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clear_i;
  logic        weight_wr_i;
  logic [1:0]  weight_ch_i;
  logic [1:0]  weight_addr_i;
  logic [31:0] weight_i;
  logic        thresh_wr_i;
  logic [7:0]  thresh_i;
  logic        pixels_valid_i;
  logic        pixels_ready_o;
  logic [31:0] pixels_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [3:0]  result_o;
  logic [31:0] result_pop_o;

  int checks = 0;
  int failures = 0;

  xnor_popcount_acc dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (clear_i),
    .weight_wr_i    (weight_wr_i),
    .weight_ch_i    (weight_ch_i),
    .weight_addr_i  (weight_addr_i),
    .weight_i       (weight_i),
    .thresh_wr_i    (thresh_wr_i),
    .thresh_i       (thresh_i),
    .pixels_valid_i (pixels_valid_i),
    .pixels_ready_o (pixels_ready_o),
    .pixels_i       (pixels_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .result_pop_o   (result_pop_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_weight(input logic [1:0] ch, input logic [1:0] addr, input logic [31:0] w);
    weight_wr_i = 1'b1; weight_ch_i = ch; weight_addr_i = addr; weight_i = w;
    tick();
    weight_wr_i = 1'b0;
  endtask

  task automatic wr_thresh(input logic [1:0] ch, input logic [7:0] t);
    thresh_wr_i = 1'b1; weight_ch_i = ch; thresh_i = t;
    tick();
    thresh_wr_i = 1'b0;
  endtask

  // n back-to-back beats of the same word.
  task automatic beats(input int n, input logic [31:0] d);
    pixels_valid_i = 1'b1; pixels_i = d;
    for (int i = 0; i < n; i++) tick();
    pixels_valid_i = 1'b0;
  endtask

  task automatic consume();
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] pop, input logic [3:0] res);
    chk({tag, "_valid"}, 32'(result_valid_o), 32'd1);
    chk({tag, "_pop"}, result_pop_o, pop);
    chk({tag, "_out"}, 32'(result_o), 32'(res));
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; weight_wr_i = 1'b0; weight_ch_i = '0;
    weight_addr_i = '0; weight_i = '0; thresh_wr_i = 1'b0; thresh_i = '0;
    pixels_valid_i = 1'b0; pixels_i = '0; result_ready_i = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_ready", 32'(pixels_ready_o), 32'd0);
    chk("rst_valid", 32'(result_valid_o), 32'd0);
    chk("rst_out", 32'(result_o), 32'd0);
    chk("rst_pop", result_pop_o, 32'd0);
    rst_ni = 1'b1;
    tick();
    chk("post_rst_ready", 32'(pixels_ready_o), 32'd1);

    // Zero weights, zero pixels: every bit matches -> 128 per channel
    beats(3, 32'h0000_0000);
    chk("lat_before_last", 32'(result_valid_o), 32'd0);
    beats(1, 32'h0000_0000);
    expect_result("zeros", 32'h8080_8080, 4'b1111);
    chk("done_ready", 32'(pixels_ready_o), 32'd0);
    consume();
    chk("consumed_valid", 32'(result_valid_o), 32'd0);
    chk("consumed_ready", 32'(pixels_ready_o), 32'd1);

    // Channel 0 weights all ones
    for (int a = 0; a < 4; a++) wr_weight(2'd0, 2'(a), 32'hFFFF_FFFF);
    beats(4, 32'h0000_0000);
    expect_result("ch0_ones", 32'h8080_8000, 4'b1110);
    consume();
    beats(4, 32'hFFFF_0000);
    expect_result("half", 32'h4040_4040, 4'b1111);
    consume();

    // Runtime thresholds at the 64 boundary
    wr_thresh(2'd1, 8'd65);
    beats(4, 32'hFFFF_0000);
    expect_result("thr65", 32'h4040_4040, 4'b1101);
    consume();
    wr_thresh(2'd1, 8'd64);
    beats(4, 32'hFFFF_0000);
    expect_result("thr64", 32'h4040_4040, 4'b1111);
    consume();

    // Weight and threshold write in the same cycle; threshold 0 and > 128
    weight_wr_i = 1'b1; weight_ch_i = 2'd2; weight_addr_i = 2'd0; weight_i = 32'hFFFF_FFFF;
    thresh_wr_i = 1'b1; thresh_i = 8'd0;
    tick();
    weight_wr_i = 1'b0; thresh_wr_i = 1'b0;
    for (int a = 1; a < 4; a++) wr_weight(2'd2, 2'(a), 32'hFFFF_FFFF);
    wr_thresh(2'd3, 8'd200);
    beats(4, 32'h0000_0000);
    expect_result("thr0_thr200", 32'h8000_8000, 4'b0110);
    consume();
    wr_thresh(2'd3, 8'd64);

    // Backpressure: hold result 5 cycles while offering beats
    beats(4, 32'h0000_0000);
    pixels_valid_i = 1'b1; pixels_i = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_result("hold", 32'h8000_8000, 4'b1110);
      chk("hold_ready", 32'(pixels_ready_o), 32'd0);
    end
    pixels_valid_i = 1'b0;
    consume();
    chk("release_ready", 32'(pixels_ready_o), 32'd1);
    beats(4, 32'hFFFF_FFFF);
    expect_result("after_hold", 32'h0080_0080, 4'b0101);
    consume();

    // Clear after 2 beats, with a beat offered in the clear cycle
    beats(2, 32'h0000_0000);
    clear_i = 1'b1; pixels_valid_i = 1'b1; pixels_i = 32'h0000_0000;
    chk("clear_ready", 32'(pixels_ready_o), 32'd1);
    tick();
    clear_i = 1'b0; pixels_valid_i = 1'b0;
    beats(3, 32'hFFFF_FFFF);
    chk("clear_no_early", 32'(result_valid_o), 32'd0);
    beats(1, 32'hFFFF_FFFF);
    expect_result("after_clear", 32'h0080_0080, 4'b0101);

    // Clear during DONE, beating result_ready
    clear_i = 1'b1; result_ready_i = 1'b1;
    tick();
    clear_i = 1'b0; result_ready_i = 1'b0;
    chk("clear_done_valid", 32'(result_valid_o), 32'd0);
    chk("clear_done_ready", 32'(pixels_ready_o), 32'd1);

    // Asynchronous reset mid-vector
    beats(3, 32'hFFFF_FFFF);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_ready", 32'(pixels_ready_o), 32'd0);
    chk("arst_valid", 32'(result_valid_o), 32'd0);
    chk("arst_out", 32'(result_o), 32'd0);
    chk("arst_pop", result_pop_o, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();
    beats(4, 32'h0000_0000);
    expect_result("post_arst", 32'h8080_8080, 4'b1111);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
